// File: rtl/lab3_mem_cache_pkg.sv
// Shared definitions for the blocking cache: controller states, memory message
// types, memory-request address select encodings and a byte-enable helper.
package lab3_mem_cache_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_TC   = 4'd1,
        ST_IN   = 4'd2,
        ST_RD   = 4'd3,
        ST_WD   = 4'd4,
        ST_EP   = 4'd5,
        ST_ER   = 4'd6,
        ST_EW   = 4'd7,
        ST_RR   = 4'd8,
        ST_RW   = 4'd9,
        ST_RU   = 4'd10,
        ST_WAIT = 4'd11
    } state_t;

    localparam logic [2:0] MSG_READ  = 3'd0;
    localparam logic [2:0] MSG_WRITE = 3'd1;
    localparam logic [2:0] MSG_INIT  = 3'd2;

    // memreq_addr_sel: evicted line address or the line holding the request
    localparam logic MEMREQ_ADDR_EVICT  = 1'b0;
    localparam logic MEMREQ_ADDR_REFILL = 1'b1;

    // refill_mux_sel: replicated request word or refill line from memory
    localparam logic REFILL_SEL_REQ = 1'b0;
    localparam logic REFILL_SEL_MEM = 1'b1;

    localparam logic [15:0] WBEN_FULL_LINE = 16'hFFFF;

    // Four byte enables for the 32-bit word selected inside a 16-byte line
    function automatic logic [15:0] word_wben(input logic [1:0] word);
        return 16'h000F << {word, 2'b00};
    endfunction

endpackage

// File: rtl/lab3_mem_blocking_cache_base_ctrl_if.sv
// Val/rdy handshakes between the cache controller, its client and memory.
// master: the environment side (client + memory); slave: the controller side.
interface lab3_mem_blocking_cache_base_ctrl_if;

    logic cachereq_val;
    logic cachereq_rdy;
    logic cacheresp_val;
    logic cacheresp_rdy;
    logic memreq_val;
    logic memreq_rdy;
    logic memresp_val;
    logic memresp_rdy;

    modport master (
        output cachereq_val,
        input  cachereq_rdy,
        input  cacheresp_val,
        output cacheresp_rdy,
        input  memreq_val,
        output memreq_rdy,
        output memresp_val,
        input  memresp_rdy
    );

    modport slave (
        input  cachereq_val,
        output cachereq_rdy,
        output cacheresp_val,
        input  cacheresp_rdy,
        output memreq_val,
        input  memreq_rdy,
        input  memresp_val,
        output memresp_rdy
    );

endinterface

// File: rtl/lab3_mem_bit_array.sv
// One flag bit per cache line with set/clear at an index and combinational
// read of the same index. Set has priority over clear.
module lab3_mem_bit_array #(
    parameter  int nblocks = 16,
    localparam int idw     = (nblocks > 1) ? $clog2(nblocks) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [idw-1:0] idx,
    input  logic           set,
    input  logic           clear,
    output logic           rdata
);

    logic [nblocks-1:0] bits;

    // Flag storage: cleared by reset, updated one line at a time
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bits <= '0;
        end else if (set) begin
            bits[idx] <= 1'b1;
        end else if (clear) begin
            bits[idx] <= 1'b0;
        end else begin
            bits <= bits;
        end
    end

    assign rdata = bits[idx];

endmodule

// File: rtl/lab3_mem_blocking_cache_base_ctrl.sv
// Control unit of the baseline blocking cache (direct-mapped, 16-byte lines,
// write-back / write-allocate). Owns all handshakes and the valid/dirty bits,
// and steers the datapath. Exactly one request is in flight at a time.
module lab3_mem_blocking_cache_base_ctrl
    import lab3_mem_cache_pkg::*;
#(
    parameter int size        = 256,
    parameter int p_idx_shamt = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    lab3_mem_blocking_cache_base_ctrl_if.slave   bus,

    output logic                                 cachereq_en,
    output logic                                 memresp_en,
    output logic                                 refill_mux_sel,
    output logic                                 tag_array_wen,
    output logic                                 data_array_wen,
    output logic [15:0]                          data_array_wben,
    output logic                                 evict_addr_reg_en,
    output logic                                 memreq_addr_sel,
    output logic [2:0]                           memreq_type,
    output logic                                 cacheresp_hit,

    input  logic [2:0]                           cachereq_type,
    input  logic [31:0]                          cachereq_addr,
    input  logic                                 tag_match
);

    localparam int nblocks = size * 8 / 128;
    localparam int idw     = $clog2(nblocks);

    state_t           state;
    state_t           next_state;
    logic [idw-1:0]   idx;
    logic             valid_rd;
    logic             dirty_rd;
    logic             hit;
    logic             is_init;
    logic             is_write;
    logic             valid_set;
    logic             dirty_set;
    logic             dirty_clear;
    logic             unused_addr;

    // Only the index and word-select bits matter here; the rest is datapath business
    assign unused_addr = ^cachereq_addr;

    assign idx      = cachereq_addr[idw+4+p_idx_shamt-1 -: idw];
    assign hit      = tag_match & valid_rd;
    assign is_init  = (cachereq_type == MSG_INIT);
    assign is_write = (cachereq_type == MSG_WRITE);

    lab3_mem_bit_array #(.nblocks(nblocks)) valid_bits (
        .clk   (clk),
        .reset (reset),
        .idx   (idx),
        .set   (valid_set),
        .clear (1'b0),
        .rdata (valid_rd)
    );

    lab3_mem_bit_array #(.nblocks(nblocks)) dirty_bits (
        .clk   (clk),
        .reset (reset),
        .idx   (idx),
        .set   (dirty_set),
        .clear (dirty_clear),
        .rdata (dirty_rd)
    );

    // Controller state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Hit status is captured at tag check and held for the response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cacheresp_hit <= 1'b0;
        end else if (state == ST_TC) begin
            cacheresp_hit <= hit;
        end else begin
            cacheresp_hit <= cacheresp_hit;
        end
    end

    // Next-state selection
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (bus.cachereq_val) next_state = ST_TC;
                else                  next_state = ST_IDLE;
            end
            ST_TC: begin
                if (is_init)                    next_state = ST_IN;
                else if (hit && is_write)       next_state = ST_WD;
                else if (hit)                   next_state = ST_RD;
                else if (valid_rd && dirty_rd)  next_state = ST_EP;
                else                            next_state = ST_RR;
            end
            ST_IN:   next_state = ST_WAIT;
            ST_RD:   next_state = ST_WAIT;
            ST_WD:   next_state = ST_WAIT;
            ST_EP:   next_state = ST_ER;
            ST_ER: begin
                if (bus.memreq_rdy) next_state = ST_EW;
                else                next_state = ST_ER;
            end
            ST_EW: begin
                if (bus.memresp_val) next_state = ST_RR;
                else                 next_state = ST_EW;
            end
            ST_RR: begin
                if (bus.memreq_rdy) next_state = ST_RW;
                else                next_state = ST_RR;
            end
            ST_RW: begin
                if (bus.memresp_val) next_state = ST_RU;
                else                 next_state = ST_RW;
            end
            ST_RU: begin
                if (is_write) next_state = ST_WD;
                else          next_state = ST_RD;
            end
            ST_WAIT: begin
                if (bus.cacheresp_rdy) next_state = ST_IDLE;
                else                   next_state = ST_WAIT;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Moore decode of datapath controls and handshakes from the current state
    always_comb begin
        bus.cachereq_rdy  = 1'b0;
        bus.cacheresp_val = 1'b0;
        bus.memreq_val    = 1'b0;
        bus.memresp_rdy   = 1'b0;
        cachereq_en       = 1'b0;
        memresp_en        = 1'b0;
        refill_mux_sel    = REFILL_SEL_REQ;
        tag_array_wen     = 1'b0;
        data_array_wen    = 1'b0;
        data_array_wben   = 16'h0000;
        evict_addr_reg_en = 1'b0;
        memreq_addr_sel   = MEMREQ_ADDR_EVICT;
        memreq_type       = MSG_READ;
        valid_set         = 1'b0;
        dirty_set         = 1'b0;
        dirty_clear       = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.cachereq_rdy = 1'b1;
                cachereq_en      = bus.cachereq_val;
            end
            ST_IN: begin
                tag_array_wen   = 1'b1;
                data_array_wen  = 1'b1;
                data_array_wben = word_wben(cachereq_addr[3:2]);
                valid_set       = 1'b1;
                dirty_clear     = 1'b1;
            end
            ST_WD: begin
                data_array_wen  = 1'b1;
                data_array_wben = word_wben(cachereq_addr[3:2]);
                dirty_set       = 1'b1;
            end
            ST_EP: begin
                evict_addr_reg_en = 1'b1;
            end
            ST_ER: begin
                bus.memreq_val  = 1'b1;
                memreq_type     = MSG_WRITE;
                memreq_addr_sel = MEMREQ_ADDR_EVICT;
            end
            ST_EW: begin
                bus.memresp_rdy = 1'b1;
            end
            ST_RR: begin
                bus.memreq_val  = 1'b1;
                memreq_type     = MSG_READ;
                memreq_addr_sel = MEMREQ_ADDR_REFILL;
            end
            ST_RW: begin
                bus.memresp_rdy = 1'b1;
                memresp_en      = bus.memresp_val;
            end
            ST_RU: begin
                refill_mux_sel  = REFILL_SEL_MEM;
                tag_array_wen   = 1'b1;
                data_array_wen  = 1'b1;
                data_array_wben = WBEN_FULL_LINE;
                valid_set       = 1'b1;
                dirty_clear     = 1'b1;
            end
            ST_WAIT: begin
                bus.cacheresp_val = 1'b1;
            end
            default: begin
                bus.cachereq_rdy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lab3_mem_blocking_cache_base_ctrl.sv
// Scoreboard bench for the blocking cache controller. The bench plays the
// client, a small datapath (request latch, tag array, evict address register)
// and a memory that answers every memory request on the following cycle.
module tb_lab3_mem_blocking_cache_base_ctrl;
    import lab3_mem_cache_pkg::*;

    typedef struct {
        logic [2:0]  t;
        logic [31:0] a;
    } mreq_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cachereq_en, memresp_en, refill_mux_sel, tag_array_wen, data_array_wen;
    logic [15:0] data_array_wben;
    logic        evict_addr_reg_en, memreq_addr_sel, cacheresp_hit;
    logic [2:0]  memreq_type;
    logic [2:0]  cur_type = 3'd0;
    logic [31:0] cur_addr = 32'h0;
    logic [31:0] evict_addr = 32'h0;
    logic [2:0]  req_type = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [23:0] tags [16] = '{default: 24'h0};
    logic        tag_match;

    mreq_t exp_mem_q [$];
    int    exp_hit_q [$];
    int    n_checks = 0;
    int    n_errors = 0;

    lab3_mem_blocking_cache_base_ctrl_if bus ();

    lab3_mem_blocking_cache_base_ctrl #(.size(256), .p_idx_shamt(0)) dut (
        .clk               (clk),
        .reset             (reset),
        .bus               (bus),
        .cachereq_en       (cachereq_en),
        .memresp_en        (memresp_en),
        .refill_mux_sel    (refill_mux_sel),
        .tag_array_wen     (tag_array_wen),
        .data_array_wen    (data_array_wen),
        .data_array_wben   (data_array_wben),
        .evict_addr_reg_en (evict_addr_reg_en),
        .memreq_addr_sel   (memreq_addr_sel),
        .memreq_type       (memreq_type),
        .cacheresp_hit     (cacheresp_hit),
        .cachereq_type     (cur_type),
        .cachereq_addr     (cur_addr),
        .tag_match         (tag_match)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: request latch, tag array and evict address register
    assign tag_match = (tags[cur_addr[7:4]] == cur_addr[31:8]);
    always @(posedge clk) begin
        if (cachereq_en) begin
            cur_type <= req_type;
            cur_addr <= req_addr;
        end
        if (tag_array_wen) tags[cur_addr[7:4]] <= cur_addr[31:8];
        if (evict_addr_reg_en) evict_addr <= {tags[cur_addr[7:4]], cur_addr[7:4], 4'h0};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_mem(input logic [2:0] t, input logic [31:0] a);
        mreq_t m;
        m.t = t;
        m.a = a;
        exp_mem_q.push_back(m);
    endtask

    // One cache transaction; exp_hit < 0 skips the hit check, exp_lat = 0 skips latency
    task automatic xact(input logic [2:0] t, input logic [31:0] a, input int exp_hit,
                        input int exp_lat, input int mem_stall, input int resp_stall,
                        input bit rst_in_rw);
        int          n;
        int          mstall;
        int          rstall;
        int          h;
        bit          done;
        bit          resp_pending;
        bit          refill_due;
        bit          mhold;
        bit          rhold;
        logic [2:0]  last_t;
        logic [31:0] obs_addr;
        logic [15:0] exp_wben;
        mreq_t       m;
        @(negedge clk);
        check_eq("idle_rdy", {31'h0, bus.cachereq_rdy}, 32'h1);
        req_type = t;
        req_addr = a;
        bus.cachereq_val = 1'b1;
        #1;
        check_eq("accept_en", {31'h0, cachereq_en}, 32'h1);
        exp_hit_q.push_back(exp_hit);
        n = 0; mstall = 0; rstall = 0; done = 1'b0; resp_pending = 1'b0;
        refill_due = 1'b0; mhold = 1'b0; rhold = 1'b0; last_t = MSG_READ;
        exp_wben = 16'h000F << (a[3:2] * 4);
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
            bus.cachereq_val = 1'b0;
            if (rst_in_rw && bus.memresp_rdy) begin
                reset = 1'b1;
                bus.memresp_val = 1'b0;
                #1;
                check_eq("rst_req_rdy", {31'h0, bus.cachereq_rdy}, 32'h1);
                check_eq("rst_memreq_val", {31'h0, bus.memreq_val}, 32'h0);
                check_eq("rst_memresp_rdy", {31'h0, bus.memresp_rdy}, 32'h0);
                check_eq("rst_resp_val", {31'h0, bus.cacheresp_val}, 32'h0);
                check_eq("rst_hit", {31'h0, cacheresp_hit}, 32'h0);
                if (exp_hit_q.size() > 0) h = exp_hit_q.pop_front();
                done = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end else begin
                check_eq("busy_req_rdy", {31'h0, bus.cachereq_rdy}, 32'h0);
                if (mhold) check_eq("memreq_hold", {31'h0, bus.memreq_val}, 32'h1);
                if (rhold) check_eq("resp_hold", {31'h0, bus.cacheresp_val}, 32'h1);
                bus.memresp_val = resp_pending;
                if (bus.memreq_val) begin
                    if (exp_mem_q.size() > 0) begin
                        m = exp_mem_q[0];
                        check_eq("memreq_type", {29'h0, memreq_type}, {29'h0, m.t});
                        check_eq("memreq_sel", {31'h0, memreq_addr_sel},
                                 (m.t == MSG_READ) ? 32'h1 : 32'h0);
                    end
                    bus.memreq_rdy = (mstall >= mem_stall);
                    if (mstall < mem_stall) mstall++;
                end else begin
                    bus.memreq_rdy = 1'b1;
                end
                if (bus.cacheresp_val) begin
                    bus.cacheresp_rdy = (rstall >= resp_stall);
                    if (rstall < resp_stall) rstall++;
                end else begin
                    bus.cacheresp_rdy = 1'b1;
                end
                #1;
                if (data_array_wen) begin
                    if (refill_due) begin
                        check_eq("refill_wben", {16'h0, data_array_wben}, 32'h0000FFFF);
                        check_eq("refill_sel", {31'h0, refill_mux_sel}, 32'h1);
                        refill_due = 1'b0;
                    end else if (t == MSG_READ) begin
                        check_eq("read_no_write", 32'h1, 32'h0);
                    end else begin
                        check_eq("word_wben", {16'h0, data_array_wben}, {16'h0, exp_wben});
                        check_eq("word_sel", {31'h0, refill_mux_sel}, 32'h0);
                    end
                end
                if (bus.memresp_val && bus.memresp_rdy) begin
                    check_eq("memresp_en", {31'h0, memresp_en},
                             (last_t == MSG_READ) ? 32'h1 : 32'h0);
                    if (last_t == MSG_READ) refill_due = 1'b1;
                    resp_pending = 1'b0;
                end
                if (bus.memreq_val && bus.memreq_rdy) begin
                    obs_addr = memreq_addr_sel ? {cur_addr[31:4], 4'h0} : evict_addr;
                    if (exp_mem_q.size() > 0) begin
                        m = exp_mem_q.pop_front();
                        check_eq("memreq_addr", obs_addr, m.a);
                        last_t = m.t;
                    end else begin
                        check_eq("memreq_unexpected", obs_addr, 32'hFFFFFFFF);
                        last_t = memreq_type;
                    end
                    resp_pending = 1'b1;
                end
                mhold = bus.memreq_val && !bus.memreq_rdy;
                rhold = bus.cacheresp_val && !bus.cacheresp_rdy;
                if (bus.cacheresp_val && bus.cacheresp_rdy) begin
                    h = (exp_hit_q.size() > 0) ? exp_hit_q.pop_front() : -1;
                    if (h >= 0) check_eq("resp_hit", {31'h0, cacheresp_hit}, h);
                    if (exp_lat > 0) check_eq("hit_latency", n, exp_lat);
                    done = 1'b1;
                end
            end
        end
        if (!done) check_eq("timeout", 32'h0, 32'h1);
        check_eq("memreq_missing", exp_mem_q.size(), 32'h0);
        exp_mem_q.delete();
        bus.memresp_val = 1'b0;
        bus.memreq_rdy  = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        bus.cachereq_val  = 1'b0;
        bus.cacheresp_rdy = 1'b1;
        bus.memreq_rdy    = 1'b1;
        bus.memresp_val   = 1'b0;
        #1;
        check_eq("reset_req_rdy", {31'h0, bus.cachereq_rdy}, 32'h1);
        check_eq("reset_resp_val", {31'h0, bus.cacheresp_val}, 32'h0);
        check_eq("reset_memreq_val", {31'h0, bus.memreq_val}, 32'h0);
        check_eq("reset_memresp_rdy", {31'h0, bus.memresp_rdy}, 32'h0);
        check_eq("reset_hit", {31'h0, cacheresp_hit}, 32'h0);
        check_eq("reset_wen", {30'h0, data_array_wen, tag_array_wen}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        xact(MSG_INIT,  32'h0000_0000, -1, 3, 0, 0, 1'b0);
        xact(MSG_READ,  32'h0000_0000,  1, 3, 0, 0, 1'b0);
        push_mem(MSG_READ, 32'h0000_1000);
        xact(MSG_READ,  32'h0000_1000,  0, 0, 0, 0, 1'b0);
        xact(MSG_WRITE, 32'h0000_1004,  1, 3, 0, 0, 1'b0);
        push_mem(MSG_WRITE, 32'h0000_1000);
        push_mem(MSG_READ,  32'h0000_1100);
        xact(MSG_READ,  32'h0000_1100,  0, 0, 0, 0, 1'b0);
        push_mem(MSG_READ, 32'h0000_1200);
        xact(MSG_READ,  32'h0000_1200,  0, 0, 4, 5, 1'b0);
        xact(MSG_INIT,  32'h0000_0010, -1, 3, 0, 0, 1'b0);
        xact(MSG_WRITE, 32'h0000_0018,  1, 3, 0, 0, 1'b0);
        push_mem(MSG_READ, 32'h0000_1000);
        xact(MSG_READ,  32'h0000_1000, -1, 0, 0, 0, 1'b1);
        push_mem(MSG_READ, 32'h0000_1000);
        xact(MSG_READ,  32'h0000_1000,  0, 0, 0, 0, 1'b0);
        push_mem(MSG_READ, 32'h0000_0010);
        xact(MSG_READ,  32'h0000_0010,  0, 0, 0, 0, 1'b0);
        xact(MSG_READ,  32'h0000_0010,  1, 3, 0, 0, 1'b0);
        push_mem(MSG_READ, 32'h0000_2000);
        xact(MSG_WRITE, 32'h0000_2008,  0, 0, 0, 0, 1'b0);
        push_mem(MSG_WRITE, 32'h0000_2000);
        push_mem(MSG_READ,  32'h0000_3000);
        xact(MSG_READ,  32'h0000_3000,  0, 0, 0, 0, 1'b0);
        xact(3'd5,      32'h0000_300C,  1, 3, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
